// File: rtl/alu_pkg.sv
// Shared opcode encodings, FSM state type and op classification for alu_mc.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_MULU = 4'b0011;
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_SLTU = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_PASS = 4'b1000;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b1010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // True for the ops that go through the bit-serial multiply/divide engine.
  function automatic logic is_iter(input logic [3:0] op);
    return (op == OP_MULU) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// Bit-serial unsigned multiply (shift-add) and restoring divide engine.
// One bit per clock; res_lo/res_hi present the value the registers take on the
// current edge, so the caller can capture the final answer on the edge where
// last is high without an extra pipeline cycle.
module alu_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic             div_sel,
  output logic             div_zero,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  logic             run_reg;
  logic             div_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [WIDTH-1:0] hi_reg;    // product high half / partial remainder
  logic [WIDTH-1:0] lo_reg;    // multiplier shifting out, product low in / dividend out, quotient in
  logic [WIDTH-1:0] opnd_reg;  // multiplicand / divisor

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

  // One iteration step. For division the borrow bit (div_diff[WIDTH]) decides
  // restore vs keep; with a zero divisor it never borrows, which naturally
  // yields an all-ones quotient and a remainder equal to the dividend.
  always_comb begin
    mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
    div_shift = {hi_reg, lo_reg[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_reg};
    hi_next   = mul_sum[WIDTH:1];
    lo_next   = {mul_sum[0], lo_reg[WIDTH-1:1]};
    if (div_reg) begin
      hi_next = div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
      lo_next = {lo_reg[WIDTH-2:0], ~div_diff[WIDTH]};
    end
  end

  assign last     = run_reg && (cnt_reg == CNT_W'(WIDTH - 1));
  assign div_sel  = div_reg;
  assign div_zero = div_reg && (opnd_reg == '0);
  assign res_lo   = lo_next;
  assign res_hi   = hi_next;

  // Operand latch on start, then one shift/add or shift/subtract per edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      run_reg  <= 1'b0;
      div_reg  <= 1'b0;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= '0;
      opnd_reg <= '0;
    end else if (start) begin
      run_reg  <= 1'b1;
      div_reg  <= is_div;
      cnt_reg  <= '0;
      hi_reg   <= '0;
      lo_reg   <= a;
      opnd_reg <= b;
    end else if (run_reg) begin
      hi_reg  <= hi_next;
      lo_reg  <= lo_next;
      cnt_reg <= cnt_reg + CNT_W'(1);
      if (last) begin
        run_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle arithmetic/logic datapath, start/busy/done FSM,
// registered results and architected N/Z/V/C flags.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flag_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zout,
  output logic             illegal,
  output logic             div0,
  output logic             status_n,
  output logic             status_z,
  output logic             status_v,
  output logic             status_c
);

  state_t state_reg, state_next;

  logic             we_reg;
  logic [WIDTH-1:0] result_reg, result_hi_reg;
  logic             illegal_reg, div0_reg;
  logic             n_reg, z_reg, v_reg, c_reg;

  // Single-cycle datapath signals
  logic [WIDTH:0]   add_full, sub_full;
  logic             add_v, sub_v, slt_bit, sltu_bit;
  logic [WIDTH-1:0] sc_res;
  logic             sc_v, sc_c, sc_legal;

  // Iterator handshake
  logic             iter_start, it_last, it_div, it_div_zero;
  logic [WIDTH-1:0] it_lo, it_hi;

  // Values captured into the output registers on the DONE-entry edge
  logic             cap;
  logic [WIDTH-1:0] cap_res, cap_hi;
  logic             cap_v, cap_c, cap_ill, cap_div0, cap_we;

  assign add_full = {1'b0, a} + {1'b0, b};
  assign sub_full = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign add_v    = (a[WIDTH-1] == b[WIDTH-1]) && (add_full[WIDTH-1] != a[WIDTH-1]);
  assign sub_v    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_full[WIDTH-1] != a[WIDTH-1]);
  // N^V of a-b stays correct when the subtraction overflows.
  assign slt_bit  = sub_full[WIDTH-1] ^ sub_v;
  assign sltu_bit = ~sub_full[WIDTH];

  // Single-cycle result and V/C; compares and logic ops leave V=C=0.
  always_comb begin
    sc_res   = '0;
    sc_v     = 1'b0;
    sc_c     = 1'b0;
    sc_legal = 1'b1;
    case (op)
      OP_ADD:  begin sc_res = add_full[WIDTH-1:0]; sc_v = add_v; sc_c = add_full[WIDTH]; end
      OP_SUB:  begin sc_res = sub_full[WIDTH-1:0]; sc_v = sub_v; sc_c = sub_full[WIDTH]; end
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, slt_bit};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, sltu_bit};
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_NOR:  sc_res = ~(a | b);
      OP_XOR:  sc_res = a ^ b;
      OP_PASS: sc_res = a;
      default: sc_legal = 1'b0;
    endcase
  end

  alu_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .srst     (reset),
    .start    (iter_start),
    .is_div   (op == OP_DIVU),
    .a        (a),
    .b        (b),
    .last     (it_last),
    .div_sel  (it_div),
    .div_zero (it_div_zero),
    .res_lo   (it_lo),
    .res_hi   (it_hi)
  );

  // Next-state logic and selection of the values committed on DONE entry.
  always_comb begin
    state_next = state_reg;
    iter_start = 1'b0;
    cap        = 1'b0;
    cap_res    = '0;
    cap_hi     = '0;
    cap_v      = 1'b0;
    cap_c      = 1'b0;
    cap_ill    = 1'b0;
    cap_div0   = 1'b0;
    cap_we     = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (is_iter(op)) begin
            state_next = S_RUN;
            iter_start = 1'b1;
          end else begin
            state_next = S_DONE;
            cap        = 1'b1;
            cap_res    = sc_res;
            cap_v      = sc_v;
            cap_c      = sc_c;
            cap_ill    = ~sc_legal;
            cap_we     = flag_we & sc_legal;
          end
        end
      end
      S_RUN: begin
        if (it_last) begin
          state_next = S_DONE;
          cap        = 1'b1;
          cap_res    = it_lo;
          cap_hi     = it_hi;
          cap_c      = ~it_div & (|it_hi);
          cap_div0   = it_div_zero;
          cap_we     = we_reg;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // State, latched flag enable, result registers and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      we_reg        <= 1'b0;
      result_reg    <= '0;
      result_hi_reg <= '0;
      illegal_reg   <= 1'b0;
      div0_reg      <= 1'b0;
      n_reg         <= 1'b0;
      z_reg         <= 1'b0;
      v_reg         <= 1'b0;
      c_reg         <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= cap & cap_ill;
      div0_reg    <= cap & cap_div0;
      if (iter_start) begin
        we_reg <= flag_we;
      end
      if (cap) begin
        result_reg    <= cap_res;
        result_hi_reg <= cap_hi;
        if (cap_we) begin
          n_reg <= cap_res[WIDTH-1];
          z_reg <= (cap_res == '0);
          v_reg <= cap_v;
          c_reg <= cap_c;
        end
      end
    end
  end

  assign busy      = (state_reg == S_RUN);
  assign done      = (state_reg == S_DONE);
  assign result    = result_reg;
  assign result_hi = result_hi_reg;
  assign zout      = ~|result_reg;
  assign illegal   = illegal_reg;
  assign div0      = div0_reg;
  assign status_n  = n_reg;
  assign status_z  = z_reg;
  assign status_v  = v_reg;
  assign status_c  = c_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): directed cases followed by random
// ops, each compared against an arithmetic reference model.
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [3:0] T_AND  = 4'b0000, T_OR   = 4'b0001, T_ADD  = 4'b0010,
                         T_MULU = 4'b0011, T_DIVU = 4'b0100, T_SLTU = 4'b0101,
                         T_SUB  = 4'b0110, T_SLT  = 4'b0111, T_PASS = 4'b1000,
                         T_XOR  = 4'b1001, T_NOR  = 4'b1010;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         flag_we = 1'b0;
  logic         busy, done, zout, illegal, div0;
  logic         status_n, status_z, status_v, status_c;
  logic [W-1:0] result, result_hi;

  int passed = 0;
  int total  = 0;

  // Flag state the model expects the DUT to hold: {N,Z,V,C}
  logic [3:0] mflags = 4'b0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [W-1:0] hi;
    logic         v, c, ill, d0;
  } exp_t;

  alu_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .flag_we(flag_we), .busy(busy), .done(done), .result(result),
    .result_hi(result_hi), .zout(zout), .illegal(illegal), .div0(div0),
    .status_n(status_n), .status_z(status_z), .status_v(status_v),
    .status_c(status_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  // Reference behaviour computed with wide integer arithmetic.
  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    longint sx, sy, s;
    longint unsigned ux, uy, p;
    longint maxs, mins;
    e    = '0;
    sx   = longint'($signed(x));
    sy   = longint'($signed(y));
    ux   = longint'(x);
    uy   = longint'(y);
    maxs = (longint'(1) << (W - 1)) - 1;
    mins = -(longint'(1) << (W - 1));
    case (o)
      T_ADD: begin
        e.res = x + y;
        s     = sx + sy;
        e.v   = (s > maxs) || (s < mins);
        e.c   = ((ux + uy) >> W) != 0;
      end
      T_SUB: begin
        e.res = x - y;
        s     = sx - sy;
        e.v   = (s > maxs) || (s < mins);
        e.c   = (x >= y);
      end
      T_SLT:  e.res = (sx < sy) ? 1 : 0;
      T_SLTU: e.res = (x < y) ? 1 : 0;
      T_AND:  e.res = x & y;
      T_OR:   e.res = x | y;
      T_NOR:  e.res = ~(x | y);
      T_XOR:  e.res = x ^ y;
      T_PASS: e.res = x;
      T_MULU: begin
        p     = ux * uy;
        e.res = p[W-1:0];
        e.hi  = p[2*W-1:W];
        e.c   = (e.hi != 0);
      end
      T_DIVU: begin
        if (y == 0) begin
          e.res = '1;
          e.hi  = x;
          e.d0  = 1'b1;
        end else begin
          e.res = x / y;
          e.hi  = x % y;
        end
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Issue one op from IDLE, wait (bounded) for done, check everything.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic we);
    exp_t e;
    bit   iter;
    int   lat, nbusy;
    e    = model(o, x, y);
    iter = (o == T_MULU) || (o == T_DIVU);
    op = o; a = x; b = y; flag_we = we; start = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs: the DUT must use its latched copies.
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; flag_we = 1'($urandom);
    lat = 1; nbusy = 0;
    while (!done && lat <= W + 4) begin
      if (busy) nbusy++;
      if (iter) start = 1'($urandom);  // start pulses while busy must be ignored
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    if (we && !e.ill) mflags = {e.res[W-1], (e.res == 0), e.v, e.c};
    $display("%s op=%b a=%h b=%h we=%0b -> result=%h hi=%h lat=%0d flags=%b",
             tag, o, x, y, we, result, result_hi, lat, {status_n, status_z, status_v, status_c});
    chk({tag, ".done"}, done, 1);
    chk({tag, ".latency"}, lat, iter ? W + 1 : 1);
    chk({tag, ".busy_cycles"}, nbusy, iter ? W : 0);
    chk({tag, ".result"}, result, e.res);
    chk({tag, ".result_hi"}, result_hi, e.hi);
    chk({tag, ".zout"}, zout, (e.res == 0));
    chk({tag, ".illegal"}, illegal, e.ill);
    chk({tag, ".div0"}, div0, e.d0);
    chk({tag, ".flags"}, {status_n, status_z, status_v, status_c}, mflags);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, {done, busy, illegal, div0}, 4'b0);
    chk({tag, ".result_hold"}, result, e.res);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 1;
      2: return '1;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return W'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [3:0] optab [11] = '{T_ADD, T_SUB, T_SLT, T_SLTU, T_AND, T_OR,
                             T_NOR, T_XOR, T_PASS, T_MULU, T_DIVU};

  initial begin
    bit saw_done;
    logic [3:0] ro;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    $display("reset: busy=%0b done=%0b result=%h zout=%0b", busy, done, result, zout);
    chk("reset.ctl", {busy, done, illegal, div0}, 4'b0);
    chk("reset.result", {result, result_hi}, 64'h0);
    chk("reset.zout", zout, 1);
    chk("reset.flags", {status_n, status_z, status_v, status_c}, 4'b0);

    run_op("add_ovf", T_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
    run_op("sub_eq", T_SUB, 32'd5, 32'd5, 1'b1);
    run_op("slt_ovf", T_SLT, 32'h8000_0000, 32'h1, 1'b1);
    run_op("mulu", T_MULU, 32'hFFFF_FFFF, 32'h2, 1'b1);
    run_op("divu", T_DIVU, 32'd100, 32'd7, 1'b1);
    run_op("divu0", T_DIVU, 32'd9, 32'd0, 1'b1);
    run_op("illegal", 4'b1111, 32'h1234, 32'h5678, 1'b1);
    run_op("add_nowe", T_ADD, 32'h8000_0000, 32'h8000_0000, 1'b0);

    // Reset in the middle of a multiply.
    op = T_MULU; a = 32'hDEAD_BEEF; b = 32'h1234_5678; flag_we = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    mflags = 4'b0;
    $display("midreset: busy=%0b done=%0b result=%h flags=%b", busy, done, result,
             {status_n, status_z, status_v, status_c});
    chk("midreset.ctl", {busy, done, illegal, div0}, 4'b0);
    chk("midreset.result", {result, result_hi}, 64'h0);
    chk("midreset.zout", zout, 1);
    chk("midreset.flags", {status_n, status_z, status_v, status_c}, 4'b0);
    saw_done = 1'b0;
    for (int i = 0; i < W + 4; i++) begin
      @(posedge clk); #1;
      if (done || busy) saw_done = 1'b1;
    end
    chk("midreset.no_done", saw_done, 0);
    run_op("add_after_reset", T_ADD, 32'd2, 32'd3, 1'b1);

    // Random ops, including occasional illegal encodings.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 11) == 0) ro = 4'($urandom_range(11, 15));
      else ro = optab[$urandom_range(0, 10)];
      run_op($sformatf("rnd%0d", i), ro, pick(), pick(), 1'($urandom));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
